// File: rtl/slot_sched_pkg.sv
// Shared widths, FSM encoding and descriptor helpers for the RX slot descriptor scheduler.
package slot_sched_pkg;

  localparam int RISCV_CORES   = 8;
  localparam int RISCV_SLOTS   = 16;
  localparam int CORE_NO_WIDTH = $clog2(RISCV_CORES);
  localparam int SLOT_NO_WIDTH = $clog2(RISCV_SLOTS);
  localparam int DESC_WIDTH    = CORE_NO_WIDTH + SLOT_NO_WIDTH;
  localparam int CNT_WIDTH     = DESC_WIDTH + 1;
  localparam int POOL_SLOTS    = RISCV_CORES * RISCV_SLOTS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  typedef logic [CORE_NO_WIDTH-1:0]                  core_no_t;
  typedef logic [SLOT_NO_WIDTH-1:0]                  slot_no_t;
  typedef logic [DESC_WIDTH-1:0]                     desc_t;
  typedef logic [CNT_WIDTH-1:0]                      cnt_t;
  // Packed so that the flattened bit index of [core][slot] equals the descriptor value.
  typedef logic [RISCV_CORES-1:0][RISCV_SLOTS-1:0]   pool_t;

  localparam cnt_t POOL_FULL = cnt_t'(POOL_SLOTS);

  function automatic core_no_t desc_core(input desc_t d);
    return d[DESC_WIDTH-1:SLOT_NO_WIDTH];
  endfunction

  function automatic slot_no_t desc_slot(input desc_t d);
    return d[SLOT_NO_WIDTH-1:0];
  endfunction

  function automatic desc_t desc_pack(input core_no_t c, input slot_no_t s);
    return {c, s};
  endfunction

endpackage

// File: rtl/slot_desc_scheduler_rr_core_select.sv
// Combinational rotate-priority encoder: first set bit at or above rr_ptr_i, wrapping.
// Used for the round-robin core pick and, with rr_ptr_i = 0, for the lowest free slot.
module rr_core_select #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] eligible_i,
  input  logic [W-1:0] rr_ptr_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  logic [W-1:0] cand_s;

  // Scan N positions starting at the pointer; W-bit addition wraps naturally.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand_s  = '0;
    for (int i = 0; i < N; i++) begin
      cand_s = rr_ptr_i + W'(i);
      if (!found_o && eligible_i[cand_s]) begin
        idx_o   = cand_s;
        found_o = 1'b1;
      end else begin
        idx_o   = idx_o;
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/slot_desc_scheduler.sv
// RX slot pool owner: per-core free bitmaps, round-robin descriptor grants, release intake.
// Optional duplicate-release pulse is built when SLOT_SCHED_DUP_CHECK_EN is defined.
module slot_desc_scheduler
  import slot_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [RISCV_CORES-1:0] core_mask,
  input  logic [DESC_WIDTH-1:0]  release_desc,
  input  logic                   release_valid,
  output logic                   release_ready,
  output logic [DESC_WIDTH-1:0]  rx_desc,
  output logic                   rx_desc_valid,
  input  logic                   rx_desc_ready,
  output logic [CNT_WIDTH-1:0]   free_count,
  output logic                   init_done,
  output logic                   dup_release
);

  state_e   state_q;
  logic     run_q;
  pool_t    bitmap_q;
  pool_t    bitmap_d;
  core_no_t rr_ptr_q;
  desc_t    rx_desc_q;
  logic     rx_valid_q;
  cnt_t     free_count_q;
  cnt_t     free_count_d;

  logic [RISCV_CORES-1:0] eligible_s;
  core_no_t sel_core_s;
  logic     sel_found_s;
  slot_no_t sel_slot_s;
  logic     slot_found_s;
  desc_t    grant_desc_s;
  logic     load_s;
  logic     grant_s;
  logic     rel_fire_s;
  logic     rel_dup_s;
  logic     rel_set_s;
  pool_t    set_mask_s;
  pool_t    clr_mask_s;

  // A core competes for a grant only if unmasked and holding at least one free slot.
  always_comb begin
    eligible_s = '0;
    for (int c = 0; c < RISCV_CORES; c++) begin
      eligible_s[c] = core_mask[c] & (|bitmap_q[c]);
    end
  end

  rr_core_select #(.N(RISCV_CORES)) u_core_sel (
    .eligible_i (eligible_s),
    .rr_ptr_i   (rr_ptr_q),
    .idx_o      (sel_core_s),
    .found_o    (sel_found_s)
  );

  rr_core_select #(.N(RISCV_SLOTS)) u_slot_sel (
    .eligible_i (bitmap_q[sel_core_s]),
    .rr_ptr_i   ({SLOT_NO_WIDTH{1'b0}}),
    .idx_o      (sel_slot_s),
    .found_o    (slot_found_s)
  );

  assign grant_desc_s = desc_pack(sel_core_s, sel_slot_s);
  assign load_s       = run_q & (~rx_valid_q | rx_desc_ready);
  assign grant_s      = load_s & sel_found_s & slot_found_s;

  // A release of a bit that is already free is a no-op; that also covers the bit
  // being granted this cycle, so a slot can never be both handed out and free.
  assign rel_fire_s = release_valid & run_q;
  assign rel_dup_s  = bitmap_q[desc_core(release_desc)][desc_slot(release_desc)];
  assign rel_set_s  = rel_fire_s & ~rel_dup_s;

  assign set_mask_s   = pool_t'(rel_set_s) << release_desc;
  assign clr_mask_s   = pool_t'(grant_s) << grant_desc_s;
  assign bitmap_d     = (bitmap_q | set_mask_s) & ~clr_mask_s;
  assign free_count_d = free_count_q + cnt_t'(rel_set_s) - cnt_t'(grant_s);

  // Pool FSM together with bitmap, output stage, rr pointer and free counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      run_q        <= 1'b0;
      bitmap_q     <= '0;
      rr_ptr_q     <= '0;
      rx_desc_q    <= '0;
      rx_valid_q   <= 1'b0;
      free_count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          run_q        <= 1'b0;
          bitmap_q     <= '0;
          rr_ptr_q     <= '0;
          rx_valid_q   <= 1'b0;
          free_count_q <= '0;
          state_q      <= enable ? ST_INIT : ST_IDLE;
        end
        ST_INIT: begin
          run_q        <= 1'b1;
          bitmap_q     <= '1;
          rr_ptr_q     <= '0;
          rx_valid_q   <= 1'b0;
          free_count_q <= POOL_FULL;
          state_q      <= ST_RUN;
        end
        ST_RUN: begin
          if (!enable) begin
            // Abort drops any pending grant without waiting for acceptance.
            run_q        <= 1'b0;
            bitmap_q     <= '0;
            rr_ptr_q     <= '0;
            rx_valid_q   <= 1'b0;
            free_count_q <= '0;
            state_q      <= ST_IDLE;
          end else begin
            run_q        <= 1'b1;
            bitmap_q     <= bitmap_d;
            free_count_q <= free_count_d;
            state_q      <= ST_RUN;
            if (load_s) begin
              rx_valid_q <= grant_s;
              if (grant_s) begin
                rx_desc_q <= grant_desc_s;
                rr_ptr_q  <= sel_core_s + core_no_t'(1);
              end else begin
                rx_desc_q <= rx_desc_q;
                rr_ptr_q  <= rr_ptr_q;
              end
            end else begin
              rx_valid_q <= rx_valid_q;
              rx_desc_q  <= rx_desc_q;
              rr_ptr_q   <= rr_ptr_q;
            end
          end
        end
        default: begin
          run_q        <= 1'b0;
          bitmap_q     <= '0;
          rr_ptr_q     <= '0;
          rx_valid_q   <= 1'b0;
          free_count_q <= '0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SLOT_SCHED_DUP_CHECK_EN
  logic dup_q;

  // One-cycle flag for a release that landed on an already-free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dup_q <= 1'b0;
    end else begin
      dup_q <= rel_fire_s & rel_dup_s & enable;
    end
  end

  assign dup_release = dup_q;
`else
  assign dup_release = 1'b0;
`endif

  assign release_ready = run_q;
  assign init_done     = run_q;
  assign rx_desc       = rx_desc_q;
  assign rx_desc_valid = rx_valid_q;
  assign free_count    = free_count_q;

endmodule

// File: tb/tb_slot_desc_scheduler.sv
// Scoreboard bench for slot_desc_scheduler: expected grants are queued with the stimulus
// and compared as the DUT hands them out; counters and side outputs checked inline.
module tb_slot_desc_scheduler;
  import slot_sched_pkg::*;

`ifdef SLOT_SCHED_DUP_CHECK_EN
  localparam logic DUP_EN = 1'b1;
`else
  localparam logic DUP_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   enable;
  logic [RISCV_CORES-1:0] core_mask;
  logic [DESC_WIDTH-1:0]  release_desc;
  logic                   release_valid;
  logic                   release_ready;
  logic [DESC_WIDTH-1:0]  rx_desc;
  logic                   rx_desc_valid;
  logic                   rx_desc_ready;
  logic [CNT_WIDTH-1:0]   free_count;
  logic                   init_done;
  logic                   dup_release;

  desc_t sb_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  slot_desc_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .core_mask     (core_mask),
    .release_desc  (release_desc),
    .release_valid (release_valid),
    .release_ready (release_ready),
    .rx_desc       (rx_desc),
    .rx_desc_valid (rx_desc_valid),
    .rx_desc_ready (rx_desc_ready),
    .free_count    (free_count),
    .init_done     (init_done),
    .dup_release   (dup_release)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic desc_t mk(input int c, input int s);
    return desc_pack(core_no_t'(c), slot_no_t'(s));
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected order after INIT: slot-major, cores ascending, masked cores skipped.
  task automatic push_full(input logic [RISCV_CORES-1:0] mask);
    for (int s = 0; s < RISCV_SLOTS; s++) begin
      for (int c = 0; c < RISCV_CORES; c++) begin
        if (mask[c]) sb_q.push_back(mk(c, s));
      end
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int b;
    b = budget;
    while (sb_q.size() != 0 && b > 0) begin
      tick(1);
      b--;
    end
    check_eq(tag, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_release(input desc_t d);
    release_desc  = d;
    release_valid = 1'b1;
    tick(1);
    release_valid = 1'b0;
  endtask

  // Accepted grants are compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rx_desc_valid && rx_desc_ready) begin
      if (sb_q.size() == 0) check_eq("unexpected_grant", 32'(sb_q.size()), 32'd1);
      else check_eq("rx_desc", 32'(rx_desc), 32'(sb_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    enable        = 1'b0;
    core_mask     = 8'hFF;
    release_desc  = '0;
    release_valid = 1'b0;
    rx_desc_ready = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check_eq("rst_valid", 32'(rx_desc_valid), 32'd0);
    check_eq("rst_free", 32'(free_count), 32'd0);
    check_eq("rst_init_done", 32'(init_done), 32'd0);
    check_eq("rst_rel_ready", 32'(release_ready), 32'd0);
    check_eq("rst_dup", 32'(dup_release), 32'd0);

    // Full pool drain, all cores eligible.
    rx_desc_ready = 1'b1;
    push_full(8'hFF);
    enable = 1'b1;
    tick(2);
    check_eq("t1_init_done", 32'(init_done), 32'd1);
    check_eq("t1_free_full", 32'(free_count), 32'd128);
    check_eq("t1_rel_ready", 32'(release_ready), 32'd1);
    wait_drain("t1_drain", 300);
    tick(2);
    check_eq("t1_valid_end", 32'(rx_desc_valid), 32'd0);
    check_eq("t1_free_end", 32'(free_count), 32'd0);

    // Single release on drained pool: 2-cycle latency.
    sb_q.push_back(mk(3, 5));
    do_release(mk(3, 5));
    check_eq("t2_free_after_rel", 32'(free_count), 32'd1);
    check_eq("t2_valid_early", 32'(rx_desc_valid), 32'd0);
    tick(1);
    check_eq("t2_valid", 32'(rx_desc_valid), 32'd1);
    check_eq("t2_desc", 32'(rx_desc), 32'(mk(3, 5)));
    check_eq("t2_free_after_grant", 32'(free_count), 32'd0);
    tick(1);
    check_eq("t2_valid_drop", 32'(rx_desc_valid), 32'd0);

    // Core 2 masked from INIT.
    enable = 1'b0;
    tick(1);
    check_eq("t3_idle_init_done", 32'(init_done), 32'd0);
    core_mask = 8'hFB;
    push_full(8'hFB);
    enable = 1'b1;
    tick(2);
    check_eq("t3_free_full", 32'(free_count), 32'd128);
    wait_drain("t3_drain", 300);
    tick(2);
    check_eq("t3_free_end", 32'(free_count), 32'd16);
    check_eq("t3_valid_end", 32'(rx_desc_valid), 32'd0);

    // Held grant under backpressure; releases and mask change during the hold.
    rx_desc_ready = 1'b0;
    sb_q.push_back(mk(0, 0));
    do_release(mk(0, 0));
    check_eq("t4_free_rel", 32'(free_count), 32'd17);
    tick(1);
    check_eq("t4_valid", 32'(rx_desc_valid), 32'd1);
    check_eq("t4_free_grant", 32'(free_count), 32'd16);
    sb_q.push_back(mk(1, 3));
    sb_q.push_back(mk(5, 7));
    sb_q.push_back(mk(6, 0));
    for (int i = 0; i < 10; i++) begin
      if (i == 0) do_release(mk(1, 3));
      else if (i == 1) do_release(mk(5, 7));
      else if (i == 2) do_release(mk(6, 0));
      else begin
        core_mask = 8'h00;
        tick(1);
      end
      check_eq("t4_hold_desc", 32'(rx_desc), 32'(mk(0, 0)));
      check_eq("t4_hold_valid", 32'(rx_desc_valid), 32'd1);
      check_eq("t4_hold_free", 32'(free_count), 32'(16 + ((i < 2) ? i + 1 : 3)));
    end
    core_mask     = 8'hFB;
    rx_desc_ready = 1'b1;
    wait_drain("t4_drain", 50);
    tick(2);
    check_eq("t4_free_end", 32'(free_count), 32'd16);

    // Duplicate releases with all grants blocked.
    core_mask     = 8'h00;
    rx_desc_ready = 1'b0;
    do_release(mk(4, 2));
    check_eq("t5_free_first", 32'(free_count), 32'd17);
    check_eq("t5_dup_first", 32'(dup_release), 32'd0);
    do_release(mk(4, 2));
    check_eq("t5_free_dup", 32'(free_count), 32'd17);
    check_eq("t5_dup_pulse", 32'(dup_release), 32'(DUP_EN));
    tick(1);
    check_eq("t5_dup_clear", 32'(dup_release), 32'd0);
    do_release(mk(2, 9));
    check_eq("t5_free_dup2", 32'(free_count), 32'd17);
    check_eq("t5_dup_masked", 32'(dup_release), 32'(DUP_EN));
    sb_q.push_back(mk(2, 0));
    sb_q.push_back(mk(4, 2));
    for (int s = 1; s < RISCV_SLOTS; s++) sb_q.push_back(mk(2, s));
    core_mask     = 8'hFF;
    rx_desc_ready = 1'b1;
    wait_drain("t5_drain", 100);
    tick(2);
    check_eq("t5_free_end", 32'(free_count), 32'd0);

    // Abort with a pending grant, then restart.
    rx_desc_ready = 1'b0;
    do_release(mk(1, 1));
    tick(1);
    check_eq("t6_valid_pending", 32'(rx_desc_valid), 32'd1);
    check_eq("t6_desc_pending", 32'(rx_desc), 32'(mk(1, 1)));
    enable = 1'b0;
    tick(1);
    check_eq("t6_abort_valid", 32'(rx_desc_valid), 32'd0);
    check_eq("t6_abort_free", 32'(free_count), 32'd0);
    check_eq("t6_abort_init_done", 32'(init_done), 32'd0);
    check_eq("t6_abort_rel_ready", 32'(release_ready), 32'd0);
    rx_desc_ready = 1'b1;
    push_full(8'hFF);
    enable = 1'b1;
    wait_drain("t6_drain", 300);
    tick(2);
    check_eq("t6_free_end", 32'(free_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
